// File: rtl/cdu_mode_seq.sv
// CDU moding and phase sequencer: free-running one-hot phase ring, debounced AGC discretes,
// zero/coarse-align/EEC arbitration and per-channel zero drive. CDU_MODE_STAGGER_EN selects
// staggered (one channel after another) zero pulses; otherwise all enabled channels pulse together.
module cdu_mode_seq #(
  parameter int unsigned NCH    = 3,
  parameter int unsigned NPHASE = 4,
  parameter int unsigned DEB    = 4,
  parameter int unsigned ZLEN   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              agc_z_n,
  input  logic              agc_ca_n,
  input  logic              agc_eec_n,
  input  logic [NCH-1:0]    ch_en,
  output logic [NPHASE-1:0] faz,
  output logic              iss_z,
  output logic              iss_ca,
  output logic              iss_eec,
  output logic [NCH-1:0]    cdu_z,
  output logic              busy,
  output logic              zero_done
);

  localparam int unsigned PulseLen = ZLEN * NPHASE;
  localparam int unsigned PulseW   = $clog2(PulseLen);
  localparam int unsigned DebW     = (DEB > 1) ? $clog2(DEB) : 1;

  typedef enum logic [1:0] {StIdle, StZero, StCa, StEec} state_e;

  logic [NPHASE-1:0]       faz_q;
  logic [2:0]              meta_q, sync_q, lvl_q;
  logic [2:0][DebW-1:0]    deb_cnt_q;
  logic                    z_prev_q;
  state_e                  state_q, state_d, state_eval;
  logic [NCH-1:0]          pend_q, pend_d, sel;
  logic                    run_q, run_d;
  logic [PulseW-1:0]       pcnt_q, pcnt_d;
  logic                    z_lvl, z_rise, go, seq_end, pulse_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      faz_q <= NPHASE'(1);
    end else begin
      faz_q <= {faz_q[NPHASE-2:0], faz_q[NPHASE-1]};
    end
  end

  // Bit order of the discrete vectors: 0 = zero, 1 = coarse align, 2 = error-counter enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      lvl_q     <= '0;
      deb_cnt_q <= '0;
      z_prev_q  <= 1'b0;
    end else begin
      meta_q   <= ~{agc_eec_n, agc_ca_n, agc_z_n};
      sync_q   <= meta_q;
      z_prev_q <= lvl_q[0];
      for (int i = 0; i < 3; i++) begin
        if (sync_q[i] != lvl_q[i]) begin
          if (deb_cnt_q[i] == DebW'(DEB - 1)) begin
            lvl_q[i]     <= sync_q[i];
            deb_cnt_q[i] <= '0;
          end else begin
            deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
          end
        end else begin
          deb_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign z_lvl  = lvl_q[0];
  assign z_rise = lvl_q[0] & ~z_prev_q;

  always_comb begin
    if (z_rise) begin
      state_eval = StZero;
    end else if (lvl_q[1]) begin
      state_eval = StCa;
    end else if (lvl_q[2]) begin
      state_eval = StEec;
    end else begin
      state_eval = StIdle;
    end
  end

  // Sequencing starts at the first phase-0 cycle and then runs without gaps.
  assign go         = run_q | faz_q[0];
  assign seq_end    = go & (pend_q == '0);
  assign pulse_last = (pcnt_q == PulseW'(PulseLen - 1));

`ifdef CDU_MODE_STAGGER_EN
  assign sel = pend_q & (~pend_q + NCH'(1));
`else
  assign sel = pend_q;
`endif

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    run_d     = run_q;
    pcnt_d    = pcnt_q;
    cdu_z     = '0;
    zero_done = 1'b0;
    case (state_q)
      StZero: begin
        if (go) begin
          cdu_z = sel;
        end
        zero_done = seq_end & z_lvl;
        if (!z_lvl || seq_end) begin
          state_d = state_eval;
        end else if (go) begin
          run_d  = 1'b1;
          pcnt_d = pulse_last ? '0 : pcnt_q + 1'b1;
          if (pulse_last) begin
            pend_d = pend_q & ~sel;
          end
        end
      end
      default: state_d = state_eval;
    endcase
    if (state_q != StZero && state_d == StZero) begin
      pend_d = ch_en;
      run_d  = 1'b0;
      pcnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= '0;
      run_q   <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      run_q   <= run_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign faz     = faz_q;
  assign iss_z   = z_lvl;
  assign iss_ca  = (state_q == StCa);
  assign iss_eec = (state_q == StEec);
  assign busy    = (state_q == StZero);

endmodule

// File: tb/tb_cdu_mode_seq.sv
// Self-checking bench for cdu_mode_seq: directed scenarios plus randomized discretes, checked
// against a schedule-based reference model of phases, debounced levels and zero sequences.
module tb_cdu_mode_seq;
  localparam int NCH = 3, NP = 4, DEB = 4, ZLEN = 2;
  localparam int L   = ZLEN * NP;
  localparam int OW  = NP + NCH + 5;
`ifdef CDU_MODE_STAGGER_EN
  localparam bit STAGGER = 1'b1;
`else
  localparam bit STAGGER = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic agc_z_n = 1'b1, agc_ca_n = 1'b1, agc_eec_n = 1'b1;
  logic [NCH-1:0] ch_en = '0;
  logic [NP-1:0]  faz;
  logic [NCH-1:0] cdu_z;
  logic iss_z, iss_ca, iss_eec, busy, zero_done;

  cdu_mode_seq #(.NCH(NCH), .NPHASE(NP), .DEB(DEB), .ZLEN(ZLEN)) dut (
    .clk(clk), .rst(rst), .agc_z_n(agc_z_n), .agc_ca_n(agc_ca_n), .agc_eec_n(agc_eec_n),
    .ch_en(ch_en), .faz(faz), .iss_z(iss_z), .iss_ca(iss_ca), .iss_eec(iss_eec),
    .cdu_z(cdu_z), .busy(busy), .zero_done(zero_done)
  );

  always #5 clk = ~clk;

  int checks = 0, passes = 0;

  // Reference model. mode: 0 idle, 1 zero, 2 coarse align, 3 eec.
  int ecount, mode, za, zk;
  int zch[NCH];
  int run[3];
  logic [NCH-1:0] zmask;
  bit r1[3], r2[3], lvl[3];
  bit rose;
  logic [OW-1:0] expv;
  localparam logic [OW-1:0] RstVec = {NP'(1), {(OW-NP){1'b0}}};

  function automatic logic [OW-1:0] obs_vec();
    return {faz, iss_z, iss_ca, iss_eec, cdu_z, busy, zero_done};
  endfunction

  task automatic model_reset();
    ecount = 0; mode = 0; rose = 0; za = 0; zk = 0; zmask = '0;
    for (int i = 0; i < 3; i++) begin
      r1[i] = 0; r2[i] = 0; lvl[i] = 0; run[i] = 0;
    end
  endtask

  task automatic model_enter(input int n);
    za = ((n + NP - 1) / NP) * NP;  // first phase-0 cycle at or after entry
    zmask = ch_en;
    zk = 0;
    for (int c = 0; c < NCH; c++) if (ch_en[c]) begin zch[zk] = c; zk++; end
    if (!STAGGER && zk > 0) zk = 1;
  endtask

  task automatic model_edge();
    bit ev, s;
    bit [2:0] raw;
    ecount++;
    ev = (mode != 1);
    if (mode == 1 && (!lvl[0] || ((ecount - 1) >= za && (ecount - 1 - za) == zk * L))) ev = 1;
    if (ev) begin
      if (rose) begin mode = 1; model_enter(ecount); end
      else if (lvl[1]) mode = 2;
      else if (lvl[2]) mode = 3;
      else mode = 0;
    end
    raw = {!agc_eec_n, !agc_ca_n, !agc_z_n};
    rose = 0;
    for (int i = 0; i < 3; i++) begin
      s = r2[i]; r2[i] = r1[i]; r1[i] = raw[i];
      if (s != lvl[i]) begin
        run[i]++;
        if (run[i] == DEB) begin
          lvl[i] = s; run[i] = 0;
          if (i == 0 && s) rose = 1;
        end
      end else run[i] = 0;
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    int t = ecount;
    int j, r;
    logic [NCH-1:0] z = '0;
    logic d = 1'b0;
    logic [NP-1:0] f = NP'(1) << (t % NP);
    if (mode == 1 && t >= za) begin
      j = (t - za) / L; r = (t - za) % L;
      if (j < zk) z = STAGGER ? (NCH'(1) << zch[j]) : zmask;
      else if (j == zk && r == 0) d = lvl[0];
    end
    return {f, lvl[0], mode == 2, mode == 3, z, mode == 1, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    expv = model_out();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== RstVec) $display("FAIL reset_state got %h exp %h", obs_vec(), RstVec);
    else passes++;
    @(negedge clk); rst = 1'b0; model_reset();
    for (int k = 0; k < 8; k++) begin
      tick(); checks++;
      if (obs_vec() !== expv) $display("FAIL phase_ring cyc %0d got %h exp %h", k, obs_vec(), expv);
      else passes++;
    end
  endtask

  task automatic test_debounce();
    int rose_at = -1, seen = 0;
    ch_en = '0; agc_z_n = 1'b0;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) agc_z_n = 1'b1;
      tick(); checks++; seen += int'(iss_z);
      if (obs_vec() !== expv) $display("FAIL glitch cyc %0d got %h exp %h", k, obs_vec(), expv);
      else passes++;
    end
    checks++;
    if (seen != 0) $display("FAIL glitch_iss_z got %0d high cycles exp 0", seen);
    else passes++;
    agc_z_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(); checks++;
      if (iss_z && rose_at < 0) rose_at = k;
      if (obs_vec() !== expv) $display("FAIL deb_low cyc %0d got %h exp %h", k, obs_vec(), expv);
      else passes++;
    end
    checks++;
    if (rose_at != 2 + DEB) $display("FAIL deb_latency got %0d exp %0d", rose_at, 2 + DEB);
    else passes++;
    agc_z_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(); checks++;
      if (obs_vec() !== expv) $display("FAIL deb_release cyc %0d got %h exp %h", k, obs_vec(), expv);
      else passes++;
    end
  endtask

  task automatic test_zero_seq();
    int hi[NCH];
    int done_n = 0;
    for (int c = 0; c < NCH; c++) hi[c] = 0;
    ch_en = 3'b101; agc_z_n = 1'b0;
    for (int k = 0; k < 80 && done_n == 0; k++) begin
      tick(); checks++;
      for (int c = 0; c < NCH; c++) hi[c] += int'(cdu_z[c]);
      done_n += int'(zero_done);
      if (obs_vec() !== expv) $display("FAIL zero_seq cyc %0d got %h exp %h", k, obs_vec(), expv);
      else passes++;
    end
    checks++;
    if (hi[0] != L || hi[1] != 0 || hi[2] != L)
      $display("FAIL zero_pulse_len got %0d/%0d/%0d exp %0d/0/%0d", hi[0], hi[1], hi[2], L, L);
    else passes++;
    checks++;
    if (done_n != 1) $display("FAIL zero_done_pulse got %0d exp 1", done_n);
    else passes++;
    agc_z_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick(); checks++;
      if (obs_vec() !== expv) $display("FAIL zero_release cyc %0d got %h exp %h", k, obs_vec(), expv);
      else passes++;
    end
  endtask

  task automatic test_abort();
    bit found = 0;
    int last_hi = 0, done_n = 0;
    ch_en = 3'b111; agc_z_n = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick(); checks++;
      found = STAGGER ? cdu_z[1] : (cdu_z != '0);
      if (obs_vec() !== expv) $display("FAIL abort_pre cyc %0d got %h exp %h", k, obs_vec(), expv);
      else passes++;
    end
    checks++;
    if (!found) $display("FAIL abort_reach got 0 exp 1");
    else passes++;
    agc_z_n = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick(); checks++;
      if (cdu_z != '0) last_hi = k;
      done_n += int'(zero_done);
      if (obs_vec() !== expv) $display("FAIL abort cyc %0d got %h exp %h", k, obs_vec(), expv);
      else passes++;
    end
    checks++;
    if (last_hi != 2 + DEB || done_n != 0)
      $display("FAIL abort_stop got last %0d done %0d exp last %0d done 0", last_hi, done_n, 2 + DEB);
    else passes++;
  endtask

  task automatic test_priority();
    int done_n = 0;
    ch_en = NCH'($urandom_range(1, 7));
    agc_ca_n = 1'b0; agc_eec_n = 1'b0;
    for (int ph = 0; ph < 4; ph++) begin
      if (ph == 1) agc_ca_n = 1'b1;
      if (ph == 2) agc_ca_n = 1'b0;
      if (ph == 3) agc_z_n = 1'b0;
      for (int k = 0; k < 10; k++) begin
        tick(); checks++;
        if (obs_vec() !== expv) $display("FAIL prio ph %0d got %h exp %h", ph, obs_vec(), expv);
        else passes++;
      end
      checks++;
      case (ph)
        1: if ({iss_ca, iss_eec, busy} !== 3'b010)
             $display("FAIL prio_eec got %b exp 010", {iss_ca, iss_eec, busy}); else passes++;
        3: if ({iss_ca, iss_eec, busy} !== 3'b001)
             $display("FAIL prio_zero got %b exp 001", {iss_ca, iss_eec, busy}); else passes++;
        default: if ({iss_ca, iss_eec, busy} !== 3'b100)
             $display("FAIL prio_ca got %b exp 100", {iss_ca, iss_eec, busy}); else passes++;
      endcase
    end
    for (int k = 0; k < 60 && done_n == 0; k++) begin
      tick(); checks++;
      done_n += int'(zero_done);
      if (obs_vec() !== expv) $display("FAIL prio_seq cyc %0d got %h exp %h", k, obs_vec(), expv);
      else passes++;
    end
    tick(); checks++;
    if ({done_n != 0, iss_ca, busy} !== 3'b110)
      $display("FAIL prio_restore got %b exp 110", {done_n != 0, iss_ca, busy});
    else passes++;
    agc_z_n = 1'b1; agc_ca_n = 1'b1; agc_eec_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick(); checks++;
      if (obs_vec() !== expv) $display("FAIL prio_rel cyc %0d got %h exp %h", k, obs_vec(), expv);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    ch_en = 3'b111; agc_z_n = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      tick(); checks++;
      found = (cdu_z != '0);
      if (obs_vec() !== expv) $display("FAIL rstmid_pre cyc %0d got %h exp %h", k, obs_vec(), expv);
      else passes++;
    end
    tick(); tick();
    #2 rst = 1'b1;
    #1 checks++;
    if (!found || obs_vec() !== RstVec)
      $display("FAIL rst_mid_async got %h found %0d exp %h", obs_vec(), found, RstVec);
    else passes++;
    @(negedge clk); rst = 1'b0; model_reset();
    for (int k = 0; k < 40; k++) begin
      tick(); checks++;
      if (obs_vec() !== expv) $display("FAIL rstmid_post cyc %0d got %h exp %h", k, obs_vec(), expv);
      else passes++;
    end
    agc_z_n = 1'b1;
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 120; seg++) begin
      agc_z_n   = ($urandom_range(0, 2) != 0);
      agc_ca_n  = $urandom_range(0, 1);
      agc_eec_n = $urandom_range(0, 1);
      ch_en     = NCH'($urandom);
      hold      = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 30);
      for (int k = 0; k < hold; k++) begin
        tick(); checks++;
        if (obs_vec() !== expv) $display("FAIL random seg %0d got %h exp %h", seg, obs_vec(), expv);
        else passes++;
      end
    end
    agc_z_n = 1'b1; agc_ca_n = 1'b1; agc_eec_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_zero_seq();
    test_abort();
    test_priority();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
